// File: rtl/terc4_island_decoder.sv
// TERC4 data-island decoder for one HDMI channel: tracks guard-band framing,
// decodes packet symbols to nibbles and keeps a saturating error count.
module terc4_island_decoder #(
    parameter logic [9:0]  GB_SYMBOL = 10'b0100110011,
    parameter int unsigned PKT_LEN   = 32,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       sym_in,
    input  logic             sym_valid,
    input  logic             err_clr,
    output logic [3:0]       data_out,
    output logic             data_valid,
    output logic             sop,
    output logic             eop,
    output logic             sym_err,
    output logic             frame_err,
    output logic             island_done,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_TRAIL0 = 3'd3;
    localparam logic [2:0] S_TRAIL1 = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [3:0]       data_nxt;
    logic             data_valid_nxt, sop_nxt, eop_nxt;
    logic             sym_err_nxt, frame_err_nxt, island_done_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic             is_gb;
    logic [4:0]       dec;

    // Returns {valid, nibble}; anything outside the 16 codes is invalid.
    function automatic logic [4:0] terc4_decode(input logic [9:0] s);
        logic [4:0] r;
        case (s)
            10'b1010011100: r = 5'h10;
            10'b1001100011: r = 5'h11;
            10'b1011100100: r = 5'h12;
            10'b1011100010: r = 5'h13;
            10'b0101110001: r = 5'h14;
            10'b0100011110: r = 5'h15;
            10'b0110001110: r = 5'h16;
            10'b0100111100: r = 5'h17;
            10'b1011001100: r = 5'h18;
            10'b0100111001: r = 5'h19;
            10'b0110011100: r = 5'h1a;
            10'b1011000110: r = 5'h1b;
            10'b1010001110: r = 5'h1c;
            10'b1001110001: r = 5'h1d;
            10'b0101100011: r = 5'h1e;
            10'b1011000011: r = 5'h1f;
            default:        r = 5'h00;
        endcase
        return r;
    endfunction

    assign is_gb = (sym_in == GB_SYMBOL);
    assign dec   = terc4_decode(sym_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            sop         <= 1'b0;
            eop         <= 1'b0;
            sym_err     <= 1'b0;
            frame_err   <= 1'b0;
            island_done <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            data_out    <= data_nxt;
            data_valid  <= data_valid_nxt;
            sop         <= sop_nxt;
            eop         <= eop_nxt;
            sym_err     <= sym_err_nxt;
            frame_err   <= frame_err_nxt;
            island_done <= island_done_nxt;
            err_count   <= err_count_nxt;
        end
    end

    // Framing FSM; pulse outputs default low so stalls emit nothing.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        data_nxt        = data_out;
        data_valid_nxt  = 1'b0;
        sop_nxt         = 1'b0;
        eop_nxt         = 1'b0;
        sym_err_nxt     = 1'b0;
        frame_err_nxt   = 1'b0;
        island_done_nxt = 1'b0;
        if (sym_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_gb) state_nxt = S_LEAD;
                end
                S_LEAD: begin
                    if (is_gb) begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt     = S_IDLE;
                        frame_err_nxt = 1'b1;
                    end
                end
                S_DATA: begin
                    data_nxt       = dec[3:0];
                    sym_err_nxt    = ~dec[4];
                    data_valid_nxt = 1'b1;
                    sop_nxt        = (idx == '0);
                    eop_nxt        = (idx == IDX_W'(PKT_LEN - 1));
                    if (idx == IDX_W'(PKT_LEN - 1)) begin
                        state_nxt = S_TRAIL0;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                S_TRAIL0: begin
                    if (is_gb) begin
                        state_nxt = S_TRAIL1;
                    end else begin
                        state_nxt     = S_IDLE;
                        frame_err_nxt = 1'b1;
                    end
                end
                S_TRAIL1: begin
                    state_nxt = S_IDLE;
                    if (is_gb) island_done_nxt = 1'b1;
                    else       frame_err_nxt   = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        // Count is updated on the same edge that registers the error flag.
        err_count_nxt = err_count;
        if (err_clr)
            err_count_nxt = '0;
        else if ((sym_err_nxt || frame_err_nxt) && (err_count != {ERR_W{1'b1}}))
            err_count_nxt = err_count + ERR_W'(1);
    end

endmodule
